// File: rtl/soc_glip_reg_responder.sv
// -----------------------------------------------------------------------------
// soc_glip_reg_responder
//
// Logic-side endpoint of the GLIP host channel. The block takes host command
// words from the incoming GLIP FIFO. It executes register reads and writes on a
// small control register file. For every command it returns one response word
// on the outgoing GLIP FIFO.
//
// Command format (header word):
//   [WIDTH-1]      WR flag (1 = write; the next word carries the data)
//   [WIDTH-2:AW]   reserved, must be zero (otherwise the response is ERR)
//   [AW-1:0]       register index
// Responses: read data, ACK (1) for a write, or ERR (all ones).
// Register 0 is a read-only ID register.
//
// Ports:
//   clk_logic  clock
//   rst        synchronous active-high reset (full reset)
//   com_rst    channel reset from the bridge; flushes protocol state only
//   in_data / in_valid / in_ready     command word stream
//   out_data / out_valid / out_ready  response word stream
//   reg_q      flattened register contents, register i at [i*WIDTH +: WIDTH]
//   reg_we     one-cycle pulse when a register write takes effect
//   reg_widx   index of the register written while reg_we=1
// -----------------------------------------------------------------------------
module soc_glip_reg_responder #(
    parameter int               WIDTH      = 16,
    parameter int               NREGS      = 16,
    parameter int               RESP_DEPTH = 4,
    parameter logic [WIDTH-1:0] ID         = 16'h5A01
) (
    input  logic                       clk_logic,
    input  logic                       rst,
    input  logic                       com_rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NREGS*WIDTH-1:0]     reg_q,
    output logic                       reg_we,
    output logic [$clog2(NREGS)-1:0]   reg_widx
);

    localparam int AW    = $clog2(NREGS);
    localparam int AW_F  = $clog2(RESP_DEPTH);
    localparam int PTR_W = AW_F + 1;

    localparam logic [WIDTH-1:0] ERR_WORD = '1;
    localparam logic [WIDTH-1:0] ACK_WORD = WIDTH'(1);

    typedef enum logic {
        S_HDR,
        S_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic               reg_we_q, reg_we_d;
    logic [AW-1:0]      reg_widx_q, reg_widx_d;

    logic [WIDTH-1:0]   fifo_mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               in_hs;
    logic               pop;
    logic               push;
    logic [WIDTH-1:0]   push_data;
    logic [AW-1:0]      hdr_idx;
    logic [WIDTH-1:0]   rd_val;

    // The extra pointer MSB tells a full FIFO from an empty one when the
    // address bits are equal.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW_F] != rd_ptr_q[AW_F]) &&
                        (wr_ptr_q[AW_F-1:0] == rd_ptr_q[AW_F-1:0]);

    // Both FSM states accept a word only when its response has a free slot.
    // This keeps a push from ever colliding with a full FIFO.
    assign in_ready  = ~fifo_full & ~com_rst & ~rst;
    assign in_hs     = in_valid & in_ready;

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[AW_F-1:0]];
    assign pop       = out_valid & out_ready;

    assign hdr_idx   = in_data[AW-1:0];
    assign rd_val    = (hdr_idx == '0) ? ID : regs_q[hdr_idx];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        regs_d     = regs_q;
        push       = 1'b0;
        push_data  = '0;
        reg_we_d   = 1'b0;
        reg_widx_d = reg_widx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        unique case (state_q)
            S_HDR: begin
                if (in_hs) begin
                    if (in_data[WIDTH-2:AW] != '0) begin
                        push      = 1'b1;
                        push_data = ERR_WORD;
                    end else if (!in_data[WIDTH-1]) begin
                        push      = 1'b1;
                        push_data = rd_val;
                    end else begin
                        idx_d   = hdr_idx;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (in_hs) begin
                    push = 1'b1;
                    if (idx_q == '0) begin
                        push_data = ERR_WORD;
                    end else begin
                        push_data      = ACK_WORD;
                        regs_d[idx_q]  = in_data;
                        reg_we_d       = 1'b1;
                        reg_widx_d     = idx_q;
                    end
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // Channel reset drops the protocol state and any queued responses. The
        // register file is kept. in_ready is low here, so no write can be
        // in flight.
        if (com_rst) begin
            state_d  = S_HDR;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (rst) begin
            state_q    <= S_HDR;
            idx_q      <= '0;
            reg_we_q   <= 1'b0;
            reg_widx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_we_q   <= reg_we_d;
            reg_widx_q <= reg_widx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            regs_q     <= regs_d;
        end
    end

    // Response storage holds only data. Its validity comes from the pointers.
    always_ff @(posedge clk_logic) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW_F-1:0]] <= push_data;
        end
    end

    assign reg_we   = reg_we_q;
    assign reg_widx = reg_widx_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg_out
        if (g == 0) begin : g_id
            assign reg_q[g*WIDTH +: WIDTH] = ID;
        end else begin : g_rw
            assign reg_q[g*WIDTH +: WIDTH] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_soc_glip_reg_responder.sv
module tb_soc_glip_reg_responder;

    logic         clk_logic = 1'b0;
    logic         rst       = 1'b1;
    logic         com_rst   = 1'b0;
    logic [15:0]  in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] reg_q;
    logic         reg_we;
    logic [3:0]   reg_widx;

    soc_glip_reg_responder dut (
        .clk_logic (clk_logic),
        .rst       (rst),
        .com_rst   (com_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .reg_q     (reg_q),
        .reg_we    (reg_we),
        .reg_widx  (reg_widx)
    );

    always #5 clk_logic = ~clk_logic;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          we_cnt  = 0;
    int          exp_we  = 0;
    bit          log_en  = 1'b0;
    logic [15:0] exp_q [$];
    int          resp_cyc [$];
    logic [15:0] model_regs [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_logic) cyc <= cyc + 1;

    // Response scoreboard and write-pulse counter, sampled mid-cycle
    always @(negedge clk_logic) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", 32'(out_data), 32'hDEAD_0000);
            end else begin
                check_eq("resp", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (log_en) resp_cyc.push_back(cyc);
        end
        if (!rst && reg_we) we_cnt++;
    end

    task automatic xfer(input logic [15:0] w, output int waits);
        in_data  = w;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk_logic);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                check_eq("hs_timeout_in_ready", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk_logic);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] hdr);
        if (hdr[14:4] != '0) return 16'hFFFF;
        if (hdr[3:0] == 4'd0) return 16'h5A01;
        return model_regs[hdr[3:0]];
    endfunction

    task automatic do_read(input logic [15:0] hdr);
        int w;
        xfer(hdr, w);
        exp_q.push_back(model_read(hdr));
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [15:0] val);
        int w;
        xfer({1'b1, 11'd0, idx}, w);
        xfer(val, w);
        if (idx == 4'd0) begin
            exp_q.push_back(16'hFFFF);
        end else begin
            exp_q.push_back(16'h0001);
            model_regs[idx] = val;
            exp_we++;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk_logic);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk_logic);
            t++;
        end
        #1;
        check_eq("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w;
        int tot;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;

        // Reset state
        repeat (3) @(posedge clk_logic);
        @(negedge clk_logic);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_reg_we",    32'(reg_we),    32'd0);
        check_eq("rst_reg_widx",  32'(reg_widx),  32'd0);
        @(posedge clk_logic);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        check_eq("rst_reg0_id", 32'(reg_q[15:0]), 32'h5A01);
        for (int i = 1; i < 16; i++) check_eq("rst_reg_zero", 32'(reg_q[i*16 +: 16]), 32'd0);

        // Read ID: response visible right after the accepting edge
        do_read(16'h0000);
        in_valid = 1'b0;
        check_eq("id_lat_valid", 32'(out_valid), 32'd1);
        check_eq("id_lat_data",  32'(out_data),  32'h5A01);
        check_eq("id_reg_we",    32'(reg_we),    32'd0);
        idle(2);

        // Write/readback
        do_write(4'd3, 16'hBEEF);
        in_valid = 1'b0;
        check_eq("wr_reg_we",   32'(reg_we),         32'd1);
        check_eq("wr_reg_widx", 32'(reg_widx),       32'd3);
        check_eq("wr_reg_q3",   32'(reg_q[63:48]),   32'hBEEF);
        idle(1);
        check_eq("wr_we_pulse", 32'(reg_we), 32'd0);
        do_read(16'h0003);
        idle(2);

        // Write immediately followed by a read of the same register
        do_write(4'd5, 16'h1357);
        do_read(16'h0005);
        idle(2);

        // Errors
        do_read(16'h0010);
        do_write(4'd0, 16'h1234);
        do_read(16'h0000);
        do_read(16'h8010 ^ 16'h8000 | 16'h4000);
        idle(2);
        check_eq("err_reg0", 32'(reg_q[15:0]), 32'h5A01);
        drain();

        do_write(4'd1, 16'h1111);
        do_write(4'd4, 16'h4444);
        idle(2);
        drain();

        // Backpressure: FIFO holds 4, the 5th header must stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_read(16'(i));
        in_data  = 16'h0004;
        in_valid = 1'b1;
        repeat (3) @(negedge clk_logic);
        check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid",    32'(out_valid), 32'd1);
        check_eq("bp_head_stable",  32'(out_data),  32'(exp_q[0]));
        @(posedge clk_logic);
        #1 out_ready = 1'b1;
        do_read(16'h0004);
        do_read(16'h0005);
        idle(1);
        drain();

        // Channel reset with a write pending and a response queued
        out_ready = 1'b0;
        do_read(16'h0001);
        xfer(16'h8002, w);
        in_data = 16'h1234;
        com_rst = 1'b1;
        @(negedge clk_logic);
        check_eq("crst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk_logic);
        @(posedge clk_logic);
        #1 com_rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_eq("crst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        idle(1);
        check_eq("crst_reg2", 32'(reg_q[47:32]), 32'd0);
        do_read(16'h0002);
        idle(2);
        drain();

        // Back-to-back reads with in_valid held
        log_en = 1'b1;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            xfer({12'd0, 4'(i + 8)}, w);
            exp_q.push_back(model_read({12'd0, 4'(i + 8)}));
            tot += w;
        end
        in_valid = 1'b0;
        idle(3);
        drain();
        log_en = 1'b0;
        check_eq("b2b_stalls", 32'(tot), 32'd0);
        check_eq("b2b_count",  32'(resp_cyc.size()), 32'd8);
        if (resp_cyc.size() == 8) check_eq("b2b_span", 32'(resp_cyc[7] - resp_cyc[0]), 32'd7);

        // Final state
        check_eq("we_count", 32'(we_cnt), 32'(exp_we));
        for (int i = 1; i < 16; i++) check_eq("final_reg", 32'(reg_q[i*16 +: 16]), 32'(model_regs[i]));

        // Reset while a write is pending
        xfer(16'h8006, w);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk_logic);
        #1 rst = 1'b0;
        in_data  = 16'h7777;
        in_valid = 1'b1;
        @(negedge clk_logic);
        if (in_ready) exp_q.push_back(16'hFFFF);
        @(posedge clk_logic);
        #1 in_valid = 1'b0;
        idle(2);
        drain();
        check_eq("rst_mid_reg6", 32'(reg_q[111:96]), 32'd0);
        check_eq("rst_mid_reg3", 32'(reg_q[63:48]),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/soc_glip_reg_responder.md
Name: soc_glip_reg_responder

Overview:
- Logic-side endpoint of the GLIP host channel. It consumes host command words arriving on the incoming GLIP FIFO, executes register reads and writes on a small control register file, and returns one response word per command on the outgoing GLIP FIFO.
- It sits between the GLIP bridge's fifo_in/fifo_out pair and SoC control logic. Its register contents drive on-chip control signals.

Parameters:
- WIDTH, 16, GLIP word width; must be >= AW+2, where AW = $clog2(NREGS).
- NREGS, 16, number of registers; power of two, >= 2.
- RESP_DEPTH, 4, response FIFO depth; power of two, >= 2.
- ID, 16'h5A01, read-only value of register 0, truncated or zero-extended to WIDTH.

Ports:
- clk_logic  in  1  clock
- rst  in  1  reset
- com_rst  in  1  channel reset from bridge; flushes protocol state
- in_data  in  WIDTH  host command word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- out_data  out  WIDTH  response word
- out_valid  out  1  response valid
- out_ready  in  1  host side accepts response
- reg_q  out  NREGS*WIDTH  register contents; register i at [i*WIDTH +: WIDTH]; register 0 slice = ID
- reg_we  out  1  one-cycle pulse on a successful register write
- reg_widx  out  AW  index written when reg_we=1

Behaviour:
- Reset: rst is synchronous, active-high, clock clk_logic.
  - FSM -> S_HDR; FIFO empty.
  - Registers 1..NREGS-1 = 0.
  - in_ready=0, out_valid=0, out_data=0, reg_we=0, reg_widx=0.
- Handshakes:
  - A transfer occurs on a rising edge with valid & ready.
  - out_valid/out_data stay stable until out_ready.
  - in_ready does not depend combinationally on in_valid.
- Header word fields:
  - [WIDTH-1] = WR.
  - [WIDTH-2:AW] = reserved, must be 0.
  - [AW-1:0] = register index.
- FSM:
  - S_HDR: in_ready=1 iff FIFO has >=1 free slot. On a header handshake:
    - Reserved bits nonzero -> push ERR (all ones); stay in S_HDR.
    - WR=0 -> push register value (ID for index 0); stay in S_HDR.
    - WR=1 -> latch index; go to S_DATA.
  - S_DATA: in_ready=1 iff FIFO has >=1 free slot. On a data handshake:
    - Latched index 0 -> push ERR; no write.
    - Otherwise -> write the register, pulse reg_we with reg_widx = index, push ACK (value 1).
    - Go to S_HDR.
  - Writes to register 0 and malformed headers never modify state, other than the ERR response.
- Timing:
  - Register write and reg_q update take effect the cycle after the data handshake.
  - A read issued the cycle after a write returns the new value.
- Response FIFO:
  - Circular, RESP_DEPTH entries; read/write pointers are AW_F+1 bits wide for full/empty detection.
  - out_data/out_valid are driven from the FIFO head.
  - Latency: if the FIFO is empty, the response appears on out_valid the cycle after the completing input handshake.
  - Throughput: with out_ready=1 held, reads sustain 1 command/cycle and writes 1 command per 2 cycles.
  - Simultaneous push and pop while full is disallowed, because in_ready=0 when full. Push and pop in the same cycle otherwise keeps the count unchanged.
  - When full, in_ready=0 and no command word is consumed.
  - Pointer wrap-around: no loss or duplication of responses.
- com_rst=1 (synchronous, takes priority over handshakes):
  - FSM -> S_HDR; FIFO flushed; out_valid=0 next cycle; in_ready=0 while asserted.
  - Registers are retained; a write pending in S_DATA is discarded with no ACK.
- rst mid-command: behaves as full reset; any partial write is discarded.
- Reset priority: rst > com_rst.

Test Plan:
- Read ID: after reset, host sends 16'h0000, out_ready=1 -> out_data=16'h5A01 one cycle after the handshake; reg_we stays 0.
- Write/readback: host sends 16'h8003 then 16'hBEEF -> reg_we pulse with reg_widx=3, response 16'h0001. Then host sends 16'h0003 -> response 16'hBEEF; reg_q[63:48]=16'hBEEF.
- Errors:
  - Header 16'h0010 (reserved bit set) -> response 16'hFFFF; no register change.
  - Header 16'h8000 followed by 16'h1234 -> response 16'hFFFF; register 0 still reads 16'h5A01.
- Backpressure: out_ready=0; host issues 6 reads of registers 0..5 -> in_ready drops after 4 accepted headers. Release out_ready -> responses arrive in order, the remaining 2 reads are accepted, and all 6 responses are correct including across pointer wrap.
- com_rst: host sends 16'h8002, then com_rst=1 for 2 cycles before the data word -> no ACK, FIFO empty, register 2 unchanged. After release, 16'h0002 reads 16'h0000 and the FSM is back in header mode.
- Back-to-back reads with out_ready=1: 8 consecutive headers with in_valid held -> 8 responses on consecutive cycles, in_ready never drops.
